// File: rtl/ofs_plat_prim_credit_pkg.sv
// Shared types and helpers for the credit-flow-controlled sender.
//
// Contents:
//   t_credit_state  - FSM states of the credit sender
//   credit_cnt_bits - width needed to hold a credit count of 0..n

package ofs_plat_prim_credit_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_IDLE_FLUSHED,
        ST_ERROR
    } t_credit_state;

    function automatic int credit_cnt_bits(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ofs_plat_prim_credit_sender_fifo.sv
// Small LUTRAM-style FIFO used as the sender's local holding buffer.
//
// Ports:
//   clk         in   clock
//   reset_n     in   synchronous reset, active-low
//   enq_data    in   word to enqueue
//   enq_en      in   enqueue strobe (caller guarantees notFull)
//   notFull     out  at least one free slot
//   almostFull  out  occupancy >= N_ENTRIES - THRESHOLD
//   first       out  head of the FIFO, valid when notEmpty
//   deq_en      in   dequeue strobe (caller guarantees notEmpty)
//   notEmpty    out  at least one entry held

module ofs_plat_prim_fifo_lutram #(
    parameter int N_DATA_BITS     = 32,
    parameter int N_ENTRIES       = 2,
    parameter int THRESHOLD       = 1,
    parameter int REGISTER_OUTPUT = 0
)(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_DATA_BITS-1:0] enq_data,
    input  logic                   enq_en,
    output logic                   notFull,
    output logic                   almostFull,
    output logic [N_DATA_BITS-1:0] first,
    input  logic                   deq_en,
    output logic                   notEmpty
);

    localparam int PTR_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
    localparam int CNT_W = $clog2(N_ENTRIES + 1);

    logic [N_DATA_BITS-1:0] mem [N_ENTRIES];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [CNT_W-1:0]       count;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(N_ENTRIES - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (enq_en) begin
            mem[wr_ptr] <= enq_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (deq_en) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({enq_en, deq_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign notFull    = (count < CNT_W'(N_ENTRIES));
    assign notEmpty   = (count != '0);
    assign almostFull = (count >= CNT_W'(N_ENTRIES - THRESHOLD));

    generate
        if (REGISTER_OUTPUT != 0) begin : g_reg_out
            logic [N_DATA_BITS-1:0] first_q;
            logic [PTR_W-1:0]       rd_nxt;
            logic                   bypass;

            // The new head is the incoming word when the FIFO would
            // otherwise be empty after this cycle's dequeue.
            assign rd_nxt = deq_en ? ptr_inc(rd_ptr) : rd_ptr;
            assign bypass = enq_en && ((count == '0) ||
                                       ((count == CNT_W'(1)) && deq_en));

            always_ff @(posedge clk) begin
                first_q <= bypass ? enq_data : mem[rd_nxt];
            end

            assign first = first_q;
        end else begin : g_comb_out
            assign first = mem[rd_ptr];
        end
    endgenerate

endmodule

// File: rtl/ofs_plat_prim_credit_sender.sv
// Transmit end of a credit-flow-controlled link. Words are accepted with
// ready/valid, held in a small local buffer, and launched one per cycle
// while a credit is held. The receiver returns one credit per dequeue.
//
// Ports:
//   clk            in   clock
//   reset          in   synchronous reset, active-high
//   in_data        in   upstream payload
//   in_valid       in   upstream payload valid
//   in_ready       out  registered; transfer when in_valid && in_ready
//   tx_valid       out  registered; one word launched to the receiver
//   tx_data        out  registered payload, meaningful only with tx_valid
//   credit_ret     in   credits returned this cycle
//   flush_req      in   level; stop accepting, drain, await all credits
//   flush_done     out  high while idle and fully flushed
//   credits_avail  out  current credit count
//   error          out  sticky credit-overflow indication
//
// state           | meaning
// ----------------+-----------------------------------------------------
// ST_RUN          | accepting input and sending while credits are held
// ST_DRAIN        | input blocked; sending out buffer, awaiting credits
// ST_IDLE_FLUSHED | buffer empty, all credits home; flush_done asserted
// ST_ERROR        | credit overflow seen; frozen until reset

module ofs_plat_prim_credit_sender
    import ofs_plat_prim_credit_pkg::*;
#(
    parameter int N_DATA_BITS       = 32,
    parameter int N_CREDITS         = 8,
    parameter int BUF_ENTRIES       = 2,
    parameter int RET_BITS          = 2,
    parameter bit FATAL_ON_OVERFLOW = 1'b1
)(
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [N_DATA_BITS-1:0]                in_data,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic                                  tx_valid,
    output logic [N_DATA_BITS-1:0]                tx_data,
    input  logic [RET_BITS-1:0]                   credit_ret,
    input  logic                                  flush_req,
    output logic                                  flush_done,
    output logic [credit_cnt_bits(N_CREDITS)-1:0] credits_avail,
    output logic                                  error
);

    localparam int CW = credit_cnt_bits(N_CREDITS);
    localparam logic [CW:0]   CRED_MAX  = (CW + 1)'(N_CREDITS);
    localparam logic [CW-1:0] CRED_INIT = CW'(N_CREDITS);

    t_credit_state          state;
    t_credit_state          state_next;
    logic                   send;
    logic                   enq;
    logic                   overflow;
    logic                   buf_full_next;
    logic [CW:0]            credits_next;

    logic                   buf_not_full;
    logic                   buf_almost_full;
    logic                   buf_not_empty;
    logic [N_DATA_BITS-1:0] buf_first;

    assign enq = in_valid && in_ready;

    ofs_plat_prim_fifo_lutram #(
        .N_DATA_BITS     (N_DATA_BITS),
        .N_ENTRIES       (BUF_ENTRIES),
        .THRESHOLD       (1),
        .REGISTER_OUTPUT (0)
    ) holding_buf (
        .clk        (clk),
        .reset_n    (!reset),
        .enq_data   (in_data),
        .enq_en     (enq),
        .notFull    (buf_not_full),
        .almostFull (buf_almost_full),
        .first      (buf_first),
        .deq_en     (send),
        .notEmpty   (buf_not_empty)
    );

    always_comb begin
        send = ((state == ST_RUN) || (state == ST_DRAIN)) &&
               buf_not_empty && (credits_avail != '0);

        // One extra bit so a return that overshoots N_CREDITS is visible.
        credits_next = {1'b0, credits_avail} - {{CW{1'b0}}, send} +
                       (CW + 1)'(credit_ret);

        overflow = (state != ST_ERROR) && (credits_next > CRED_MAX);

        state_next = state;
        if (overflow) begin
            state_next = ST_ERROR;
        end else begin
            case (state)
                ST_RUN: begin
                    if (flush_req) begin
                        state_next = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!buf_not_empty && (credits_next == CRED_MAX) && !send) begin
                        state_next = ST_IDLE_FLUSHED;
                    end
                end
                ST_IDLE_FLUSHED: begin
                    if (!flush_req) begin
                        state_next = ST_RUN;
                    end
                end
                default: state_next = ST_ERROR;
            endcase
        end

        // in_ready is registered, so it must predict next cycle's fullness.
        // almostFull (one slot left) tells whether a lone enqueue fills it.
        case ({enq, send})
            2'b10:   buf_full_next = buf_almost_full;
            2'b01:   buf_full_next = 1'b0;
            default: buf_full_next = !buf_not_full;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_RUN;
            credits_avail <= CRED_INIT;
            in_ready      <= 1'b0;
            tx_valid      <= 1'b0;
            tx_data       <= '0;
            flush_done    <= 1'b0;
            error         <= 1'b0;
        end else begin
            state      <= state_next;
            in_ready   <= (state_next == ST_RUN) && !buf_full_next;
            tx_valid   <= send;
            flush_done <= (state_next == ST_IDLE_FLUSHED);
            if (send) begin
                tx_data <= buf_first;
            end
            // Credit count is frozen once the link is known to be corrupt.
            if (!overflow && (state != ST_ERROR)) begin
                credits_avail <= credits_next[CW-1:0];
            end
            if (overflow) begin
                error <= 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && overflow && FATAL_ON_OVERFLOW) begin
            $fatal(1, "ofs_plat_prim_credit_sender: credit overflow");
        end
    end
`endif

endmodule

// File: tb/tb_ofs_plat_prim_credit_sender.sv
module tb_ofs_plat_prim_credit_sender;

    localparam int N   = 8;
    localparam int BUF = 2;
    localparam int DW  = 32;
    localparam int CW  = $clog2(N + 1);

    localparam int M_RUN  = 0;
    localparam int M_DRN  = 1;
    localparam int M_IDLE = 2;
    localparam int M_ERR  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic [1:0]    credit_ret;
    logic          flush_req;
    logic          flush_done;
    logic [CW-1:0] credits_avail;
    logic          error;

    always #5 clk = ~clk;

    ofs_plat_prim_credit_sender #(
        .N_DATA_BITS       (DW),
        .N_CREDITS         (N),
        .BUF_ENTRIES       (BUF),
        .RET_BITS          (2),
        .FATAL_ON_OVERFLOW (1'b0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .credit_ret    (credit_ret),
        .flush_req     (flush_req),
        .flush_done    (flush_done),
        .credits_avail (credits_avail),
        .error         (error)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: a queue of buffered words and a credit count.
    logic [DW-1:0] q[$];
    int            m_cred;
    int            m_mode;
    bit            m_in_ready, m_tx_valid, m_flush_done, m_err;
    logic [DW-1:0] m_tx_data;
    int            rx_held;
    int            tx_seen;
    int            accepted;
    logic [DW-1:0] cur_data;

    task automatic cyc(input bit rst, input bit v, input int cr, input bit fl);
        bit send;
        bit enq;
        int cn;
        int mode_n;
        reset      = rst;
        in_valid   = v;
        in_data    = cur_data;
        credit_ret = 2'(cr);
        flush_req  = fl;
        enq = 1'b0;
        if (rst) begin
            q.delete();
            m_cred = N; m_mode = M_RUN; m_in_ready = 0; m_tx_valid = 0;
            m_flush_done = 0; m_err = 0;
        end else begin
            send   = (m_mode == M_RUN || m_mode == M_DRN) && q.size() > 0 && m_cred > 0;
            enq    = v && m_in_ready;
            cn     = m_cred - int'(send) + cr;
            mode_n = m_mode;
            if (m_mode != M_ERR && cn > N) begin
                mode_n = M_ERR;
                m_err  = 1;
            end else begin
                case (m_mode)
                    M_RUN:  if (fl) mode_n = M_DRN;
                    M_DRN:  if (q.size() == 0 && cn == N) mode_n = M_IDLE;
                    M_IDLE: if (!fl) mode_n = M_RUN;
                    default: ;
                endcase
                if (m_mode != M_ERR) m_cred = cn;
            end
            m_tx_valid = send;
            if (send) m_tx_data = q.pop_front();
            if (enq) q.push_back(cur_data);
            m_mode       = mode_n;
            m_in_ready   = (mode_n == M_RUN) && (q.size() < BUF);
            m_flush_done = (mode_n == M_IDLE);
        end
        @(posedge clk);
        @(negedge clk);
        if (enq) begin
            accepted++;
            cur_data = $urandom;
        end
        if (rst) rx_held = 0;
        else if (m_tx_valid) rx_held++;
        if (tx_valid === 1'b1) tx_seen++;
        check("in_ready", in_ready, m_in_ready);
        check("tx_valid", tx_valid, m_tx_valid);
        if (m_tx_valid) check("tx_data", tx_data, m_tx_data);
        check("flush_done", flush_done, m_flush_done);
        check("credits_avail", credits_avail, m_cred);
        check("error", error, m_err);
    endtask

    task automatic step(input bit v, input int cr, input bit fl);
        rx_held = (rx_held >= cr) ? rx_held - cr : 0;
        cyc(1'b0, v, cr, fl);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit fl_r;
        int mx;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; credit_ret = '0; flush_req = 1'b0;
        cur_data = $urandom; rx_held = 0; tx_seen = 0; accepted = 0;
        @(negedge clk);
        cyc(1'b1, 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b0);
        check("rst_credits", credits_avail, N);
        check("rst_in_ready", in_ready, 0);
        check("rst_tx_valid", tx_valid, 0);

        // 1: back-to-back input, no credit return
        tx_seen = 0; accepted = 0;
        repeat (14) step(1'b1, 0, 1'b0);
        check("t1_tx_count", tx_seen, 8);
        check("t1_credits", credits_avail, 0);
        check("t1_accepted", accepted, 10);
        check("t1_in_ready", in_ready, 0);

        // 2: single credit returned -> exactly one launch
        tx_seen = 0;
        step(1'b1, 1, 1'b0);
        repeat (4) step(1'b1, 0, 1'b0);
        check("t2_tx_count", tx_seen, 1);
        check("t2_credits", credits_avail, 0);

        // 3: one credit back every cycle sustains one launch every cycle
        repeat (4) step(1'b1, 1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1, 1'b0);
            check("t3_tx_valid", tx_valid, 1);
            check("t3_credits", credits_avail, 1);
        end

        // 4: flush with words buffered and credits outstanding
        step(1'b1, 0, 1'b1);
        check("t4_in_ready_off", in_ready, 0);
        for (int i = 0; i < 60 && flush_done !== 1'b1; i++) begin
            mx = (rx_held < 2) ? rx_held : 2;
            step(1'b1, mx, 1'b1);
        end
        check("t4_flush_done", flush_done, 1);
        check("t4_credits_full", credits_avail, N);
        check("t4_in_ready_held", in_ready, 0);
        step(1'b0, 0, 1'b0);
        check("t4_in_ready_back", in_ready, 1);
        check("t4_flush_done_off", flush_done, 0);

        // 5: returning a credit while all are home is an overflow
        step(1'b0, 1, 1'b0);
        check("t5_error", error, 1);
        check("t5_in_ready", in_ready, 0);
        repeat (3) step(1'b1, 0, 1'b0);
        check("t5_tx_valid", tx_valid, 0);
        check("t5_error_sticky", error, 1);
        cyc(1'b1, 1'b0, 0, 1'b0);
        check("t5_error_cleared", error, 0);

        // 6: reset with a full buffer and 3 credits held
        repeat (14) step(1'b1, 0, 1'b0);
        step(1'b0, 3, 1'b0);
        check("t6_credits_pre", credits_avail, 3);
        cyc(1'b1, 1'b0, 0, 1'b0);
        check("t6_tx_valid", tx_valid, 0);
        check("t6_credits", credits_avail, N);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 0, 1'b0);
            check("t6_no_stale", tx_valid, 0);
        end

        // Random traffic against the model with a well-behaved receiver
        fl_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) fl_r = !fl_r;
            if ($urandom_range(0, 499) == 0) begin
                cyc(1'b1, 1'b0, 0, fl_r);
            end else begin
                mx = (rx_held < 3) ? rx_held : 3;
                step($urandom_range(0, 3) != 0, $urandom_range(0, mx), fl_r);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
